// File: rtl/matrix_1bit_line_ctrl_if.sv
// Signal bundle between the binarisation stage, the line controller and the
// 1-bit line-shift RAM / 3x3 window registers.
interface matrix_1bit_line_ctrl_if;
  logic per_frame_vsync;
  logic per_frame_href;
  logic per_frame_clken;
  logic per_img_bit;
  logic ram_href;
  logic ram_clken;
  logic ram_shiftin;
  logic mat_vsync;
  logic mat_href;
  logic mat_clken;
  logic mat_win_valid;
  logic frame_done;
  logic line_len_err;

  // Upstream pixel source: drives the frame stream, observes the controller.
  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
    input  ram_href, ram_clken, ram_shiftin,
    input  mat_vsync, mat_href, mat_clken, mat_win_valid,
    input  frame_done, line_len_err
  );

  // Line controller side.
  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
    output ram_href, ram_clken, ram_shiftin,
    output mat_vsync, mat_href, mat_clken, mat_win_valid,
    output frame_done, line_len_err
  );
endinterface

// File: rtl/matrix_1bit_line_ctrl.sv
// Line-buffer sequencer for the 3x3 binary matrix generator.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_IDLE      | after reset; pixels ignored until a vsync rising edge
// S_WAIT_LINE | frame open, waiting for href of the next line (col=0)
// S_LINE      | inside a line; pixels accepted while col < IMG_W
// S_DONE      | last line ended; pixels ignored until next vsync rise
module matrix_1bit_line_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CNT_W    = 10,
  parameter int PIPE_LAT = 3
) (
  input  logic                    i_clock,
  input  logic                    i_rst_n,
  matrix_1bit_line_ctrl_if.slave  io_bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LINE = 2'd1,
    S_LINE      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_COL_MAX  = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] LP_ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] LP_TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_col;
  logic [CNT_W-1:0]   r_row;
  logic [CNT_W-1:0]   w_col_nxt;
  logic [CNT_W-1:0]   w_row_nxt;

  logic               r_vsync_q;
  logic               r_href_q;
  logic               r_line_len_err;
  logic               r_frame_done;

  logic               w_vsync_rise;
  logic               w_href_fall;
  logic               w_accept;
  logic               w_err_set;
  logic               w_done_set;
  logic               w_win_ok;
  logic               w_in_frame;

  logic               r_ram_href;
  logic               r_ram_clken;
  logic               r_ram_shiftin;
  logic               r_win_ok;

  logic [PIPE_LAT-1:0] r_dly_vsync;
  logic [PIPE_LAT-1:0] r_dly_href;
  logic [PIPE_LAT-1:0] r_dly_clken;
  logic [PIPE_LAT-1:0] r_dly_win;

  assign w_vsync_rise = io_bus.per_frame_vsync & ~r_vsync_q;
  assign w_href_fall  = ~io_bus.per_frame_href & r_href_q;
  // Window is complete once two full rows and two columns precede this pixel.
  assign w_win_ok     = (r_row >= LP_TWO) && (r_col >= LP_TWO);
  assign w_in_frame   = (r_state == S_WAIT_LINE) || (r_state == S_LINE);

  // Next-state, counter and event decode; a vsync rise overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    w_done_set  = 1'b0;
    if (w_vsync_rise) begin
      w_state_nxt = S_WAIT_LINE;
      w_col_nxt   = '0;
      w_row_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_WAIT_LINE: begin
          w_col_nxt = '0;
          if (io_bus.per_frame_href) begin
            w_state_nxt = S_LINE;
            if (io_bus.per_frame_clken) begin
              w_accept  = 1'b1;
              w_col_nxt = LP_ONE;
            end
          end
        end
        S_LINE: begin
          if (io_bus.per_frame_href && io_bus.per_frame_clken) begin
            if (r_col < LP_COL_MAX) begin
              w_accept  = 1'b1;
              w_col_nxt = r_col + LP_ONE;
            end else begin
              w_err_set = 1'b1;
            end
          end
          if (w_href_fall) begin
            if (r_col != LP_COL_MAX) begin
              w_err_set = 1'b1;
            end
            if (r_row == LP_ROW_LAST) begin
              w_state_nxt = S_DONE;
              w_done_set  = 1'b1;
            end else begin
              w_row_nxt   = r_row + LP_ONE;
              w_state_nxt = S_WAIT_LINE;
            end
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, position counters, edge-detect history and status flags.
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_col          <= '0;
      r_row          <= '0;
      r_vsync_q      <= 1'b0;
      r_href_q       <= 1'b0;
      r_frame_done   <= 1'b0;
      r_line_len_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_vsync_q    <= io_bus.per_frame_vsync;
      r_href_q     <= io_bus.per_frame_href;
      r_frame_done <= w_done_set;
      if (w_vsync_rise) begin
        r_line_len_err <= 1'b0;
      end else if (w_err_set) begin
        r_line_len_err <= 1'b1;
      end
    end
  end

  // RAM-facing stage: gated strobe, pixel and href, plus the window flag.
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_ram_href    <= 1'b0;
      r_ram_clken   <= 1'b0;
      r_ram_shiftin <= 1'b0;
      r_win_ok      <= 1'b0;
    end else begin
      r_ram_href    <= io_bus.per_frame_href & w_in_frame;
      r_ram_clken   <= w_accept;
      r_ram_shiftin <= io_bus.per_img_bit;
      r_win_ok      <= w_accept & w_win_ok;
    end
  end

  // Delay lines matching the line-buffer tap latency.
  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      r_dly_vsync <= '0;
      r_dly_href  <= '0;
      r_dly_clken <= '0;
      r_dly_win   <= '0;
    end else begin
      r_dly_vsync[0] <= r_vsync_q;
      r_dly_href[0]  <= r_ram_href;
      r_dly_clken[0] <= r_ram_clken;
      r_dly_win[0]   <= r_win_ok;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dly_vsync[i] <= r_dly_vsync[i-1];
        r_dly_href[i]  <= r_dly_href[i-1];
        r_dly_clken[i] <= r_dly_clken[i-1];
        r_dly_win[i]   <= r_dly_win[i-1];
      end
    end
  end

  assign io_bus.ram_href      = r_ram_href;
  assign io_bus.ram_clken     = r_ram_clken;
  assign io_bus.ram_shiftin   = r_ram_shiftin;
  assign io_bus.mat_vsync     = r_dly_vsync[PIPE_LAT-1];
  assign io_bus.mat_href      = r_dly_href[PIPE_LAT-1];
  assign io_bus.mat_clken     = r_dly_clken[PIPE_LAT-1];
  assign io_bus.mat_win_valid = r_dly_clken[PIPE_LAT-1] & r_dly_win[PIPE_LAT-1];
  assign io_bus.frame_done    = r_frame_done;
  assign io_bus.line_len_err  = r_line_len_err;

endmodule

// File: tb/tb_matrix_1bit_line_ctrl.sv
// Scoreboard bench for matrix_1bit_line_ctrl with an 8x4 image.
module tb_matrix_1bit_line_ctrl;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_1bit_line_ctrl_if bus ();

  matrix_1bit_line_ctrl #(
    .IMG_W(W), .IMG_H(H), .CNT_W(10), .PIPE_LAT(LAT)
  ) dut (
    .i_clock(clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  typedef struct {
    logic b;
    logic w;
    int   c;
  } exp_t;

  exp_t q_ram[$];
  exp_t q_mat[$];
  int   q_done[$];
  int   q_vs[$];

  int   tests    = 0;
  int   failed   = 0;
  int   cyc      = 0;
  int   ram_cnt  = 0;
  int   win_cnt  = 0;
  int   done_cnt = 0;
  logic prev_vs  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter used to time-stamp expected responses.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  initial begin
    exp_t e;
    int   d;
    logic mvs_q;
    mvs_q = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ram_clken === 1'b1) begin
        ram_cnt++;
        if (q_ram.size() == 0) check("ram_clken unexpected", 1, 0);
        else begin
          e = q_ram.pop_front();
          check("ram_shiftin", bus.ram_shiftin, e.b);
          check("ram_clken cycle", cyc, e.c);
        end
      end
      if (bus.mat_clken === 1'b1) begin
        if (bus.mat_win_valid === 1'b1) win_cnt++;
        if (q_mat.size() == 0) check("mat_clken unexpected", 1, 0);
        else begin
          e = q_mat.pop_front();
          check("mat_win_valid", bus.mat_win_valid, e.w);
          check("mat_clken cycle", cyc, e.c);
        end
      end
      if (bus.mat_win_valid === 1'b1 && bus.mat_clken !== 1'b1)
        check("win_valid without mat_clken", 1, 0);
      if (bus.frame_done === 1'b1) begin
        done_cnt++;
        if (q_done.size() == 0) check("frame_done unexpected", 1, 0);
        else begin
          d = q_done.pop_front();
          check("frame_done cycle", cyc, d);
        end
      end
      if (bus.mat_vsync === 1'b1 && mvs_q !== 1'b1) begin
        if (q_vs.size() == 0) check("mat_vsync unexpected", 1, 0);
        else begin
          d = q_vs.pop_front();
          check("mat_vsync cycle", cyc, d);
        end
      end
      mvs_q = bus.mat_vsync;
    end
  end

  // One input cycle; optionally registers the expected RAM/window response.
  task automatic drive(input logic vs, input logic h, input logic ck, input logic b,
                       input bit push, input logic win);
    exp_t e;
    bus.per_frame_vsync = vs;
    bus.per_frame_href  = h;
    bus.per_frame_clken = ck;
    bus.per_img_bit     = b;
    if (vs && !prev_vs) q_vs.push_back(cyc + 1 + LAT);
    prev_vs = vs;
    if (push) begin
      e.b = b; e.w = win; e.c = cyc + 1;
      q_ram.push_back(e);
      e.c = cyc + 1 + LAT;
      q_mat.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Line of n strobes at the given row; only the first W are forwarded when active.
  task automatic send_line(input int n, input int row, input bit active, input bit sparse);
    logic b;
    logic act;
    act = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = ((i + row) % 3) == 0;
      drive(1'b0, 1'b1, 1'b1, b, active && (i < W), (row >= 2) && (i >= 2));
      act |= bus.ram_href | bus.ram_clken;
      if (sparse) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        act |= bus.ram_href | bus.ram_clken;
      end
    end
    if (active && row == H - 1) q_done.push_back(cyc + 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      act |= bus.ram_href | bus.ram_clken;
    end
    if (!active) check("inactive line ram activity", act, 0);
  endtask

  function automatic logic [8:0] all_outs();
    return {bus.ram_href, bus.ram_clken, bus.ram_shiftin, bus.mat_vsync, bus.mat_href,
            bus.mat_clken, bus.mat_win_valid, bus.frame_done, bus.line_len_err};
  endfunction

  initial begin
    int r0, w0, d0;
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_img_bit     = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", all_outs(), 0);
    rst_n = 1'b1;
    idle(2);

    // Pixels before any vsync are ignored.
    send_line(W, 0, 1'b0, 1'b0);

    // Frame 1: nominal 8x4, first line with gapped strobes.
    r0 = ram_cnt; w0 = win_cnt; d0 = done_cnt;
    vsync_pulse();
    send_line(W, 0, 1'b1, 1'b1);
    for (int r = 1; r < H; r++) send_line(W, r, 1'b1, 1'b0);
    idle(6);
    check("f1 ram_clken count", ram_cnt - r0, 32);
    check("f1 win_valid count", win_cnt - w0, 12);
    check("f1 frame_done count", done_cnt - d0, 1);
    check("f1 line_len_err", bus.line_len_err, 0);

    // Frame 2: lines of 8, 10, 5, 8 pixels.
    r0 = ram_cnt; w0 = win_cnt; d0 = done_cnt;
    vsync_pulse();
    send_line(8, 0, 1'b1, 1'b0);
    check("f2 err after line 1", bus.line_len_err, 0);
    send_line(10, 1, 1'b1, 1'b0);
    check("f2 err after long line", bus.line_len_err, 1);
    send_line(5, 2, 1'b1, 1'b0);
    check("f2 err after short line", bus.line_len_err, 1);
    send_line(8, 3, 1'b1, 1'b0);
    idle(6);
    check("f2 ram_clken count", ram_cnt - r0, 29);
    check("f2 win_valid count", win_cnt - w0, 9);
    check("f2 frame_done count", done_cnt - d0, 1);
    // Extra line after the frame completed.
    send_line(8, 0, 1'b0, 1'b0);
    idle(6);
    check("f2 extra line ram count", ram_cnt - r0, 29);
    check("f2 extra line done count", done_cnt - d0, 1);
    check("f2 err sticky", bus.line_len_err, 1);

    // Frame 3: vsync rises together with href/clken; that pixel is dropped.
    r0 = ram_cnt; d0 = done_cnt;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("vsync rise clears err", bus.line_len_err, 0);
    check("vsync-cycle pixel dropped", bus.ram_clken, 0);
    send_line(W, 0, 1'b1, 1'b0);
    check("f3 err after line 1", bus.line_len_err, 0);
    for (int r = 1; r < H; r++) send_line(W, r, 1'b1, 1'b0);
    idle(6);
    check("f3 ram_clken count", ram_cnt - r0, 32);
    check("f3 frame_done count", done_cnt - d0, 1);

    // Frame 4: reset pulse in the middle of line 2.
    d0 = done_cnt;
    vsync_pulse();
    send_line(W, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, i[0], 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre-reset mat_href", bus.mat_href, 1);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("mid-frame reset outputs", all_outs(), 0);
    send_line(4, 1, 1'b0, 1'b0);
    send_line(W, 2, 1'b0, 1'b0);
    send_line(W, 3, 1'b0, 1'b0);
    idle(6);
    check("post-reset no frame_done", done_cnt - d0, 0);

    // Frame 5: recovery after a fresh vsync.
    r0 = ram_cnt; w0 = win_cnt; d0 = done_cnt;
    vsync_pulse();
    for (int r = 0; r < H; r++) send_line(W, r, 1'b1, 1'b0);
    idle(8);
    check("f5 ram_clken count", ram_cnt - r0, 32);
    check("f5 win_valid count", win_cnt - w0, 12);
    check("f5 frame_done count", done_cnt - d0, 1);

    check("ram queue drained", q_ram.size(), 0);
    check("mat queue drained", q_mat.size(), 0);
    check("done queue drained", q_done.size(), 0);
    check("vsync queue drained", q_vs.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, tests %0d failed %0d", tests, failed);
    $fatal(1, "watchdog");
  end

endmodule
